op_class_dispatch: RTL
======================

# op_class_dispatch

Arbitrated opcode dispatcher in front of the casez opcode classifier. Up to NREQ requesters present 7-bit opcodes over valid/ready. A round-robin arbiter picks one per cycle, the shared classifier maps it to one of five class codes, and a one-entry output stage issues it to the matching class unit. Opcodes the classifier rejects are consumed and reported on an error pulse, never issued.

## Interface
- NREQ, default 4: number of requesters, range 2..8.
- SRCW, default $clog2(NREQ): source-index width, derived and not overridden.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester opcode valid.
- req_op  input  NREQ x 7  per-requester opcode.
- req_ready  output  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- iss_valid  output  1  output stage holds a legal opcode.
- iss_cls  output  3  class code 1..5.
- iss_op  output  7  opcode being issued.
- iss_src  output  SRCW  index of the requester that sent it.
- cls_ready  input  5  class-unit ready; bit k accepts class k+1.
- err_valid  output  1  one-cycle pulse: an illegal opcode was consumed.
- err_src  output  SRCW  requester index of the illegal opcode; valid only with err_valid.
- err_seen  output  1  sticky; set by any illegal opcode, cleared only by reset.

## Operation
- Classifier, applied to op[3:0] and valid only when op[6:4]==0:
  - 0?00 -> 1
  - 0?01 -> 2
  - 1??1 -> 3
  - 1??0 -> 4
  - 0?1? -> 5
  - The patterns are disjoint. Any nonzero op[6:4] is illegal.
- Stage state is EMPTY or FULL.
- drain = FULL and cls_ready[iss_cls-1].
- Arbitration:
  - Enabled when the stage is EMPTY or drain is true. req_ready therefore depends combinationally on cls_ready.
  - Grant goes to the first valid requester at or after rr_ptr, scanning upward and wrapping.
  - After any grant, rr_ptr becomes the grant index plus 1, modulo NREQ.
  - With no valid requester, rr_ptr holds and no grant is made.
- Legal granted opcode: loaded into the stage, which becomes or stays FULL. Back-to-back issue is 1 per cycle.
- Illegal granted opcode:
  - Consumed.
  - Stage becomes EMPTY if drain is true, otherwise holds.
  - err_valid=1 and err_src=grant index in the next cycle.
  - err_seen is set.
- Drain with no grant: stage becomes EMPTY.
- While FULL and not drained: iss_* are held stable and no grant is made.
- A requester may drop req_valid before it is granted; no state is affected.

## Timing
- Reset values:
  - req_ready=0, iss_valid=0, iss_cls=0, iss_op=0, iss_src=0.
  - err_valid=0, err_src=0, err_seen=0.
  - rr_ptr=0, stage EMPTY, counters 0.
- Latency: an opcode accepted at edge t is on iss_* in the cycle after t. Illegal opcodes raise err_valid in the cycle after t.
- req_ready is low during reset.
- Reset asserted mid-operation discards the stage contents without issuing them. The first grant after reset goes to the lowest valid index.
- iss_valid never depends combinationally on req_valid; iss_* come from registers only.

## Configuration
- OPCLS_STATS_EN defined: adds output stat_cnt (6 x 16).
  - Entries 0..4 count completed issues of classes 1..5.
  - Entry 5 counts illegal opcodes.
  - Counters saturate at 16'hFFFF and reset to 0.
- OPCLS_STATS_EN undefined: no counters and no stat_cnt port. All other behaviour is identical.

## Structure
- Package op_cls_pkg holds:
  - op_t (logic [6:0]) and cls_t (logic [2:0]).
  - The five pattern localparams and CLS_ILLEGAL = 3'd0.
  - Automatic function op_classify(op_t) returning cls_t, using unique casez with default CLS_ILLEGAL.
- Sub-module op_rr_arb: NREQ-wide round-robin arbiter with a pointer register, taking enable and returning a one-hot grant plus index. The dispatcher owns the stage, the error logic and the counters.

## Test plan
- NREQ=4. Requesters 0 and 2 send 7'h00 and 7'h05, all cls_ready high -> issue (cls1, src0) then (cls2, src2) in consecutive cycles; rr_ptr ends at 3.
- All four requesters valid continuously with legal ops, cls_ready all high -> grants 0,1,2,3,0 and one issue per cycle.
- Requester 1 sends 7'h1A -> req_ready[1] pulses, err_valid=1 with err_src=1 next cycle, err_seen stays 1, iss_valid stays 0.
- Stage holds 7'h09 (cls3) with cls_ready[2]=0 for 3 cycles -> iss_* stable, req_ready=0; raise cls_ready[2] -> issue, with a same-cycle grant loading the next op.
- Reset asserted while the stage is FULL -> next cycle iss_valid=0, err_seen=0, rr_ptr=0; a pending requester 3 is granted after reset drops.
- With OPCLS_STATS_EN: 3 cls4 issues plus 2 illegal opcodes -> stat_cnt[3]=3, stat_cnt[5]=2; preload near saturation -> holds at 16'hFFFF.

Source files
------------

// File: rtl/op_cls_pkg.sv
// rtl/op_cls_pkg.sv - opcode/class types, classifier patterns and classify function
package op_cls_pkg;

    typedef logic [6:0] op_t;
    typedef logic [2:0] cls_t;

    localparam logic [3:0] PAT_CLS1 = 4'b0?00;
    localparam logic [3:0] PAT_CLS2 = 4'b0?01;
    localparam logic [3:0] PAT_CLS3 = 4'b1??1;
    localparam logic [3:0] PAT_CLS4 = 4'b1??0;
    localparam logic [3:0] PAT_CLS5 = 4'b0?1?;

    localparam cls_t CLS_ILLEGAL = 3'd0;

    // Only op[3:0] is decoded; any nonzero high nibble is rejected outright.
    function automatic cls_t op_classify(input op_t op);
        cls_t c;
        c = CLS_ILLEGAL;
        if (op[6:4] == 3'b000) begin
            unique casez (op[3:0])
                PAT_CLS1: c = 3'd1;
                PAT_CLS2: c = 3'd2;
                PAT_CLS3: c = 3'd3;
                PAT_CLS4: c = 3'd4;
                PAT_CLS5: c = 3'd5;
                default:  c = CLS_ILLEGAL;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/op_rr_arb.sv
// rtl/op_rr_arb.sv - round-robin arbiter with pointer register and enable
module op_rr_arb #(
    parameter  int NREQ = 4,
    localparam int SRCW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [SRCW-1:0] grant_idx,
    output logic            grant_valid
);

    logic [SRCW-1:0] r_ptr;
    logic            w_found;
    logic [SRCW-1:0] w_idx;
    int              w_j;

    // First requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_j = int'(r_ptr) + i;
            if (w_j >= NREQ) w_j = w_j - NREQ;
            if (!w_found && req[w_j]) begin
                w_found = 1'b1;
                w_idx   = SRCW'(w_j);
            end
        end
    end

    assign grant_valid = en && w_found;
    assign grant_idx   = w_idx;
    assign grant       = grant_valid ? (NREQ'(1) << w_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (grant_valid) begin
            r_ptr <= (w_idx == SRCW'(NREQ - 1)) ? '0 : w_idx + SRCW'(1);
        end
    end

endmodule

// File: rtl/op_class_dispatch.sv
// rtl/op_class_dispatch.sv - arbitrated opcode dispatcher; OPCLS_STATS_EN adds stat_cnt
module op_class_dispatch
    import op_cls_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int SRCW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0][6:0] req_op,
    output logic [NREQ-1:0]      req_ready,
    output logic                 iss_valid,
    output logic [2:0]           iss_cls,
    output logic [6:0]           iss_op,
    output logic [SRCW-1:0]      iss_src,
    input  logic [4:0]           cls_ready,
    output logic                 err_valid,
    output logic [SRCW-1:0]      err_src,
    output logic                 err_seen
`ifdef OPCLS_STATS_EN
   ,output logic [5:0][15:0]     stat_cnt
`endif
);

    logic            r_full;
    cls_t            r_cls;
    op_t             r_op;
    logic [SRCW-1:0] r_src;
    logic            r_err_valid;
    logic [SRCW-1:0] r_err_src;
    logic            r_err_seen;

    logic [7:0]      w_rdy_ext;
    logic            w_drain;
    logic            w_en;
    logic            w_gnt_valid;
    logic [SRCW-1:0] w_gnt_idx;
    op_t             w_gnt_op;
    cls_t            w_gnt_cls;
    logic            w_illegal;

    // Class k lives at bit k so r_cls indexes directly; bit 0 (empty class) reads 0.
    assign w_rdy_ext = {2'b00, cls_ready, 1'b0};
    assign w_drain   = r_full && w_rdy_ext[r_cls];
    assign w_en      = !reset && (!r_full || w_drain);

    op_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .en          (w_en),
        .req         (req_valid),
        .grant       (req_ready),
        .grant_idx   (w_gnt_idx),
        .grant_valid (w_gnt_valid)
    );

    assign w_gnt_op  = req_op[w_gnt_idx];
    assign w_gnt_cls = op_classify(w_gnt_op);
    assign w_illegal = w_gnt_valid && (w_gnt_cls == CLS_ILLEGAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full      <= 1'b0;
            r_cls       <= '0;
            r_op        <= '0;
            r_src       <= '0;
            r_err_valid <= 1'b0;
            r_err_src   <= '0;
            r_err_seen  <= 1'b0;
        end else begin
            r_err_valid <= 1'b0;
            if (w_gnt_valid && !w_illegal) begin
                r_full <= 1'b1;
                r_cls  <= w_gnt_cls;
                r_op   <= w_gnt_op;
                r_src  <= w_gnt_idx;
            end else begin
                if (w_illegal) begin
                    r_err_valid <= 1'b1;
                    r_err_src   <= w_gnt_idx;
                    r_err_seen  <= 1'b1;
                end
                if (w_drain) r_full <= 1'b0;
            end
        end
    end

    assign iss_valid = r_full;
    assign iss_cls   = r_cls;
    assign iss_op    = r_op;
    assign iss_src   = r_src;
    assign err_valid = r_err_valid;
    assign err_src   = r_err_src;
    assign err_seen  = r_err_seen;

`ifdef OPCLS_STATS_EN
    logic [5:0][15:0] r_stat_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_cnt <= '0;
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (w_drain && r_cls == cls_t'(k + 1) && r_stat_cnt[k] != 16'hFFFF)
                    r_stat_cnt[k] <= r_stat_cnt[k] + 16'd1;
            end
            if (w_illegal && r_stat_cnt[5] != 16'hFFFF)
                r_stat_cnt[5] <= r_stat_cnt[5] + 16'd1;
        end
    end

    assign stat_cnt = r_stat_cnt;
`endif

endmodule
